// File: rtl/hazard_ctrl_sb_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Forward-select encodings and register index width helper.
package hazard_ctrl_sb_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for long-latency ops.
// Tracks outstanding destinations, their count, and protocol errors.
module hazard_scoreboard
  import hazard_ctrl_sb_pkg::*;
#(
  parameter  int NREG    = 32,
  parameter  int MAX_OUT = 4,
  localparam int AW      = aw_of(NREG),
  localparam int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  output logic [NREG-1:0] pending,
  output logic [OW-1:0]   out_cnt,
  output logic            sb_err
);

  logic            full;
  logic            do_set;
  logic            do_clr;
  logic            bad;
  logic [NREG-1:0] pend_nxt;
  logic [OW-1:0]   cnt_nxt;

  assign full   = (out_cnt == OW'(MAX_OUT));
  assign do_set = set_en & (set_idx != '0) & ~full;
  // pending[0] is never set, so a clear of x0 is always a bad clear
  assign do_clr = clr_en & pending[clr_idx];
  assign bad    = (set_en & full) | (clr_en & ~pending[clr_idx]);

  always_comb begin
    pend_nxt = pending;
    if (do_clr)
      pend_nxt[clr_idx] = 1'b0;
    if (do_set)
      pend_nxt[set_idx] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = out_cnt;
    unique case ({do_set, do_clr})
      2'b10:   cnt_nxt = out_cnt + 1'b1;
      2'b01:   cnt_nxt = out_cnt - 1'b1;
      default: cnt_nxt = out_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      out_cnt <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= pend_nxt;
      out_cnt <= cnt_nxt;
      sb_err  <= sb_err | bad;
    end
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller: forwarding, load-use and scoreboard stalls,
// branch flush, and a saturating stall-cycle counter.
module hazard_ctrl_sb
  import hazard_ctrl_sb_pkg::*;
#(
  parameter  int NREG    = 32,
  parameter  int MAX_OUT = 4,
  parameter  int CNT_W   = 16,
  localparam int AW      = aw_of(NREG),
  localparam int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    RS1_D,
  input  logic [AW-1:0]    RS2_D,
  input  logic [AW-1:0]    RD_D,
  input  logic             LongD,
  input  logic [AW-1:0]    RS1_E,
  input  logic [AW-1:0]    RS2_E,
  input  logic [AW-1:0]    RD_E,
  input  logic             RegWriteE,
  input  logic             LoadE,
  input  logic             LongIssueE,
  input  logic             PCSrcE,
  input  logic [AW-1:0]    RD_M,
  input  logic [AW-1:0]    RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LongDone,
  input  logic [AW-1:0]    LongRD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [OW-1:0]    OutCnt,
  output logic [CNT_W-1:0] StallCnt,
  output logic             SbErr
);

  logic [NREG-1:0] pending;
  logic            m_ok;
  logic            w_ok;
  logic            lw_stall;
  logic            sb_stall;
  logic            stall;
  logic            unused;

  assign unused = RegWriteE;

  hazard_scoreboard #(
    .NREG    (NREG),
    .MAX_OUT (MAX_OUT)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (LongIssueE),
    .set_idx (RD_E),
    .clr_en  (LongDone),
    .clr_idx (LongRD),
    .pending (pending),
    .out_cnt (OutCnt),
    .sb_err  (SbErr)
  );

  assign m_ok = RegWriteM & (RD_M != '0);
  assign w_ok = RegWriteW & (RD_W != '0);

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst) begin
      if (m_ok && RD_M == RS1_E)
        ForwardAE = FWD_M;
      else if (w_ok && RD_W == RS1_E)
        ForwardAE = FWD_W;
      if (m_ok && RD_M == RS2_E)
        ForwardBE = FWD_M;
      else if (w_ok && RD_W == RS2_E)
        ForwardBE = FWD_W;
    end
  end

  assign lw_stall = LoadE & (RD_E != '0) &
                    ((RD_E == RS1_D) | (RD_E == RS2_D));
  assign sb_stall = pending[RS1_D] | pending[RS2_D] |
                    (pending[RD_D] & (RD_D != '0)) |
                    (LongD & (OutCnt == OW'(MAX_OUT)));
  // a taken branch squashes D, so its hazards are moot
  assign stall    = (lw_stall | sb_stall) & ~PCSrcE;

  assign StallF = rst & stall;
  assign StallD = rst & stall;
  assign FlushD = rst & PCSrcE;
  assign FlushE = rst & (stall | PCSrcE);

  always_ff @(posedge clk) begin
    if (!rst)
      StallCnt <= '0;
    else if (StallD && StallCnt != '1)
      StallCnt <= StallCnt + 1'b1;
  end

endmodule
